// File: rtl/ntsc_tg_pkg.sv
// Shared NTSC 4fsc timing defaults, output levels and enums for the composite
// line sequencer and its chroma mux.
package ntsc_tg_pkg;

   localparam int H_W            = 10;

   localparam int TG_H_TOTAL     = 910;
   localparam int TG_SYNC_LEN    = 68;
   localparam int TG_BURST_START = 76;
   localparam int TG_BURST_LEN   = 36;
   localparam int TG_ACT_START   = 134;
   localparam int TG_ACT_LEN     = 768;
   localparam int TG_PIPE_LAT    = 2;

   localparam logic [8:0]        TG_SYNC_LVL  = 9'd4;
   localparam logic [8:0]        TG_BLANK_LVL = 9'd60;
   localparam logic [8:0]        TG_SETUP_LVL = 9'd11;
   localparam logic signed [7:0] TG_BURST_AMP = 8'sd20;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_BREEZE,
      ST_BURST,
      ST_BACKP,
      ST_ACTIVE,
      ST_FRONT
   } line_state_t;

   typedef enum logic [1:0] {
      P_U  = 2'd0,
      P_V  = 2'd1,
      P_NU = 2'd2,
      P_NV = 2'd3
   } phase_t;

   // -(-128) does not fit in 8 bits, so it clips to +127.
   function automatic logic signed [7:0] neg_sat8(input logic signed [7:0] x);
      if (x == 8'sh80)
         return 8'sh7f;
      else
         return -x;
   endfunction

   function automatic logic [8:0] sat9(input logic signed [10:0] v);
      if (v < 11'sd0)
         return 9'd0;
      else if (v > 11'sd511)
         return 9'd511;
      else
         return v[8:0];
   endfunction

endpackage

// File: rtl/ntsc_chroma_mux.sv
// Subcarrier-phase chroma select: +U, +V, -U, -V with saturating negation.
module ntsc_chroma_mux
   import ntsc_tg_pkg::*;
(
   input  logic [1:0]        phase,
   input  logic signed [7:0] u,
   input  logic signed [7:0] v,
   output logic signed [7:0] chroma
);

   always_comb begin
      chroma = u;
      case (phase_t'(phase))
         P_U:     chroma = u;
         P_V:     chroma = v;
         P_NU:    chroma = neg_sat8(u);
         P_NV:    chroma = neg_sat8(v);
         default: chroma = u;
      endcase
   end

endmodule

// File: rtl/ntsc_chroma_seq.sv
// 4fsc composite-line sequencer: h counter, subcarrier phase, line-region FSM and Y+C mixer.
// Optional 7.5 IRE pedestal on active samples when NTSC_CHROMA_SEQ_SETUP_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SYNC   | h sync tip (broad pulse on vsync lines)
// ST_BREEZE | breezeway between sync and burst
// ST_BURST  | colour burst on the -U axis
// ST_BACKP  | back porch up to the active window
// ST_ACTIVE | active video, Y + phase-selected chroma
// ST_FRONT  | blank: front porch, blanked active window, vsync line tail
module ntsc_chroma_seq
   import ntsc_tg_pkg::*;
#(
   parameter int                C_H_TOTAL     = TG_H_TOTAL,
   parameter int                C_SYNC_LEN    = TG_SYNC_LEN,
   parameter int                C_BURST_START = TG_BURST_START,
   parameter int                C_BURST_LEN   = TG_BURST_LEN,
   parameter int                C_ACT_START   = TG_ACT_START,
   parameter int                C_ACT_LEN     = TG_ACT_LEN,
   parameter int                C_PIPE_LAT    = TG_PIPE_LAT,
   parameter logic [8:0]        C_SYNC_LVL    = TG_SYNC_LVL,
   parameter logic [8:0]        C_BLANK_LVL   = TG_BLANK_LVL,
   parameter logic signed [7:0] C_BURST_AMP   = TG_BURST_AMP
)(
   input  logic       CK_i,
   input  logic       SR_i,
   input  logic       CK_EE_i,
   input  logic       HSTART_i,
   input  logic       VSYNC_i,
   input  logic       VBLANK_i,
   input  logic [7:0] YYs_i,
   input  logic [7:0] UUs_i,
   input  logic [7:0] VVs_i,
   output logic       REQ_o,
   output logic       ACTIVE_o,
   output logic       BURST_o,
   output logic [1:0] PHASE_o,
   output logic [8:0] VIDEOs_o
);

   logic [H_W-1:0]    h_q;
   logic [H_W-1:0]    h_nxt;
   logic [1:0]        phase_q;
   logic              vs_q;
   logic              vb_q;
   logic              vs_nxt;
   logic              vb_nxt;
   line_state_t       st_q;
   line_state_t       st_nxt;
   int                h_int;

   logic signed [7:0]  chroma;
   logic signed [10:0] blank_s;
   logic signed [10:0] luma_s;
   logic signed [10:0] chroma_s;
   logic signed [10:0] amp_s;
   logic signed [10:0] burst_off;
   logic signed [10:0] burst_sum;
   logic signed [10:0] act_sum;

   logic [8:0]        video_nxt;
   logic              act_nxt;
   logic              burst_nxt;
   logic              req_nxt;

   function automatic line_state_t decode(input logic [H_W-1:0] h, input logic vs, input logic vb);
      int hi;
      hi = int'(h);
      if (vs) begin
         if (hi < C_H_TOTAL / 2 - C_SYNC_LEN)
            return ST_SYNC;
         return ST_FRONT;
      end
      if (hi < C_SYNC_LEN)
         return ST_SYNC;
      if (hi < C_BURST_START)
         return ST_BREEZE;
      if (hi < C_BURST_START + C_BURST_LEN)
         return ST_BURST;
      if (hi < C_ACT_START)
         return ST_BACKP;
      if (hi < C_ACT_START + C_ACT_LEN)
         return vb ? ST_FRONT : ST_ACTIVE;
      return ST_FRONT;
   endfunction

   ntsc_chroma_mux u_chroma_mux (
      .phase  (phase_q),
      .u      (UUs_i),
      .v      (VVs_i),
      .chroma (chroma)
   );

   assign h_int     = int'(h_q);
   assign blank_s   = signed'({2'b00, C_BLANK_LVL});
   assign luma_s    = signed'({3'b000, YYs_i});
   assign chroma_s  = {{3{chroma[7]}}, chroma};
   assign amp_s     = {{3{C_BURST_AMP[7]}}, C_BURST_AMP};
   assign burst_sum = blank_s + burst_off;

`ifdef NTSC_CHROMA_SEQ_SETUP_EN
   assign act_sum = blank_s + luma_s + chroma_s + signed'({2'b00, TG_SETUP_LVL});
`else
   assign act_sum = blank_s + luma_s + chroma_s;
`endif

   // Burst sits on the -U axis: negative at phase 0, positive at phase 2.
   always_comb begin
      burst_off = '0;
      case (phase_t'(phase_q))
         P_U:     burst_off = -amp_s;
         P_NU:    burst_off = amp_s;
         default: burst_off = '0;
      endcase
   end

   always_comb begin
      h_nxt     = h_q;
      vs_nxt    = vs_q;
      vb_nxt    = vb_q;
      st_nxt    = st_q;
      video_nxt = C_BLANK_LVL;
      act_nxt   = 1'b0;
      burst_nxt = 1'b0;

      if (CK_EE_i) begin
         if (HSTART_i || h_q == H_W'(C_H_TOTAL - 1))
            h_nxt = '0;
         else
            h_nxt = h_q + H_W'(1);
         if (h_nxt == '0) begin
            vs_nxt = VSYNC_i;
            vb_nxt = VBLANK_i;
         end
         st_nxt = decode(h_nxt, vs_nxt, vb_nxt);
      end

      case (st_q)
         ST_SYNC:   video_nxt = C_SYNC_LVL;
         ST_BURST: begin
            video_nxt = sat9(burst_sum);
            burst_nxt = 1'b1;
         end
         ST_ACTIVE: begin
            video_nxt = sat9(act_sum);
            act_nxt   = 1'b1;
         end
         default:   video_nxt = C_BLANK_LVL;
      endcase
   end

   // Registered alongside the video path, so REQ_o leads ACTIVE_o by C_PIPE_LAT at the ports.
   assign req_nxt = !vs_q && !vb_q
                    && (h_int >= C_ACT_START - C_PIPE_LAT)
                    && (h_int <  C_ACT_START + C_ACT_LEN - C_PIPE_LAT);

   always_ff @(posedge CK_i) begin
      if (SR_i) begin
         h_q      <= '0;
         phase_q  <= '0;
         vs_q     <= 1'b0;
         vb_q     <= 1'b0;
         st_q     <= ST_SYNC;
         VIDEOs_o <= C_BLANK_LVL;
         REQ_o    <= 1'b0;
         ACTIVE_o <= 1'b0;
         BURST_o  <= 1'b0;
         PHASE_o  <= '0;
      end else if (CK_EE_i) begin
         h_q      <= h_nxt;
         phase_q  <= phase_q + 2'd1;
         vs_q     <= vs_nxt;
         vb_q     <= vb_nxt;
         st_q     <= st_nxt;
         VIDEOs_o <= video_nxt;
         REQ_o    <= req_nxt;
         ACTIVE_o <= act_nxt;
         BURST_o  <= burst_nxt;
         PHASE_o  <= phase_q;
      end
   end

endmodule

// File: tb/tb_ntsc_chroma_seq.sv
// Randomised bench for ntsc_chroma_seq against a line-timing reference model.
module tb_ntsc_chroma_seq;

   localparam int H_TOTAL = 910;
   localparam int R_SYNC  = 0;
   localparam int R_BLANK = 1;
   localparam int R_BURST = 2;
   localparam int R_ACT   = 3;
`ifdef NTSC_CHROMA_SEQ_SETUP_EN
   localparam int SETUP = 11;
`else
   localparam int SETUP = 0;
`endif

   logic       ck = 1'b0;
   logic       sr, ck_ee, hstart, vsync, vblank;
   logic [7:0] yy, uu, vv;
   logic       req, act, burst;
   logic [1:0] phase;
   logic [8:0] video;
   logic       req_h, act_h, burst_h;
   logic [1:0] phase_h;
   logic [8:0] video_h;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int sy, su, sv;
   int m_h, m_ph;
   bit m_vs, m_vb;
   int e_video, e_video_h, e_act, e_burst, e_req, e_phase;

   int act_tbl [4] = '{210, 130, 110, 190};

   always #5 ck = ~ck;

   ntsc_chroma_seq dut (
      .CK_i(ck), .SR_i(sr), .CK_EE_i(ck_ee), .HSTART_i(hstart),
      .VSYNC_i(vsync), .VBLANK_i(vblank),
      .YYs_i(yy), .UUs_i(uu), .VVs_i(vv),
      .REQ_o(req), .ACTIVE_o(act), .BURST_o(burst),
      .PHASE_o(phase), .VIDEOs_o(video)
   );

   ntsc_chroma_seq #(.C_BLANK_LVL(9'd200)) dut_hi (
      .CK_i(ck), .SR_i(sr), .CK_EE_i(ck_ee), .HSTART_i(hstart),
      .VSYNC_i(vsync), .VBLANK_i(vblank),
      .YYs_i(yy), .UUs_i(uu), .VVs_i(vv),
      .REQ_o(req_h), .ACTIVE_o(act_h), .BURST_o(burst_h),
      .PHASE_o(phase_h), .VIDEOs_o(video_h)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int region(input int h, input bit vs, input bit vb);
      if (vs) return (h < H_TOTAL / 2 - 68) ? R_SYNC : R_BLANK;
      if (h < 68) return R_SYNC;
      if (h >= 76 && h < 76 + 36) return R_BURST;
      if (!vb && h >= 134 && h < 134 + 768) return R_ACT;
      return R_BLANK;
   endfunction

   function automatic int level(input int rg, input int ph, input int y, input int u, input int v,
                                input int blank);
      int c, s;
      case (rg)
         R_SYNC:  return 4;
         R_BURST: return blank + ((ph == 0) ? -20 : (ph == 2) ? 20 : 0);
         R_ACT: begin
            c = (ph == 0) ? u : (ph == 1) ? v : (ph == 2) ? -u : -v;
            if (c > 127) c = 127;
            s = blank + y + c + SETUP;
            if (s < 0) s = 0;
            if (s > 511) s = 511;
            return s;
         end
         default: return blank;
      endcase
   endfunction

   task automatic set_yuv(input int y, input int u, input int v);
      sy = y; su = u; sv = v;
      yy = 8'(y); uu = 8'(u); vv = 8'(v);
   endtask

   task automatic rand_yuv();
      set_yuv(int'($urandom_range(255)), int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128);
   endtask

   // Advance the model for this edge, clock the DUTs, then compare all outputs.
   task automatic step();
      int rg;
      if (sr) begin
         m_h = 0; m_ph = 0; m_vs = 0; m_vb = 0;
         e_video = 60; e_video_h = 200;
         e_act = 0; e_burst = 0; e_req = 0; e_phase = 0;
      end else if (ck_ee) begin
         rg        = region(m_h, m_vs, m_vb);
         e_video   = level(rg, m_ph, sy, su, sv, 60);
         e_video_h = level(rg, m_ph, sy, su, sv, 200);
         e_act     = (rg == R_ACT) ? 1 : 0;
         e_burst   = (rg == R_BURST) ? 1 : 0;
         e_req     = (!m_vs && !m_vb && m_h >= 132 && m_h < 900) ? 1 : 0;
         e_phase   = m_ph;
         m_h       = (hstart || m_h == H_TOTAL - 1) ? 0 : m_h + 1;
         if (m_h == 0) begin
            m_vs = vsync;
            m_vb = vblank;
         end
         m_ph = (m_ph + 1) % 4;
      end
      @(posedge ck);
      #1;
      cyc++;
      check_eq("video", video, e_video);
      check_eq("video_hi", video_h, e_video_h);
      check_eq("active", act, e_act);
      check_eq("burst", burst, e_burst);
      check_eq("req", req, e_req);
      check_eq("phase", phase, e_phase);
   endtask

   initial begin
      int cnt, req_rise, act_rise, en_idx;

      sr = 1'b1; ck_ee = 1'b1; hstart = 1'b0; vsync = 1'b0; vblank = 1'b0;
      set_yuv(0, 0, 0);
      step();
      sr = 1'b0;

      // Lines 1-2: free run, black, no chroma.
      for (int i = 0; i < 2 * H_TOTAL; i++) begin
         step();
         if (i == 10)            check_eq("sync_lvl", video, 4);
         if (i == 76)            check_eq("burst_l1", video, 40);
         if (i == H_TOTAL + 76)  check_eq("burst_l2", video, 80);
      end

      // Line 3: fixed colour, window length and request lead.
      set_yuv(100, 50, -30);
      cnt = 0; req_rise = -1; act_rise = -1;
      for (int i = 0; i < H_TOTAL; i++) begin
         step();
         if (act) begin
            cnt++;
            check_eq("act_lvl", video, act_tbl[phase]);
         end
         if (req && req_rise < 0) req_rise = i;
         if (act && act_rise < 0) act_rise = i;
      end
      check_eq("act_count", cnt, 768);
      check_eq("req_lead", act_rise - req_rise, 2);

      // Line 4: top-end saturation; arm vsync for line 5.
      set_yuv(255, 127, 0);
      vsync = 1'b1;
      for (int i = 0; i < H_TOTAL; i++) begin
         step();
         if (act && phase == 2'd0) begin
            check_eq("sat_60", video, 442 + SETUP);
            check_eq("sat_200", video_h, 511);
         end
      end

      // Line 5: vsync broad pulse; arm vblank for line 6.
      vsync = 1'b0; vblank = 1'b1;
      for (int i = 0; i < H_TOTAL; i++) begin
         rand_yuv();
         step();
         check_eq("vs_lvl", video, (i < 387) ? 4 : 60);
         check_eq("vs_flags", {act, burst}, 0);
      end

      // Line 6: vblank line.
      vblank = 1'b0;
      for (int i = 0; i < H_TOTAL; i++) begin
         rand_yuv();
         step();
      end

      // Line 7: negation of -128.
      set_yuv(50, -128, -128);
      for (int i = 0; i < H_TOTAL; i++) begin
         step();
         if (act && phase == 2'd2) check_eq("neg_sat", video, 237 + SETUP);
      end

      // Lines 8-10: random colour and line flags.
      for (int l = 0; l < 3; l++) begin
         vsync  = ($urandom_range(3) == 0);
         vblank = ($urandom_range(1) == 1);
         if (l == 2) begin
            vsync = 1'b0; vblank = 1'b0;
         end
         for (int i = 0; i < H_TOTAL; i++) begin
            rand_yuv();
            step();
         end
      end

      // Mid-line restart at h=500.
      for (int i = 0; i < 2 * H_TOTAL && m_h != 500; i++) begin
         rand_yuv();
         step();
      end
      hstart = 1'b1;
      step();
      hstart = 1'b0;
      step();
      check_eq("hs_restart", video, 4);
      for (int i = 0; i < 400; i++) begin
         rand_yuv();
         step();
      end

      // Reset mid-active with the enable low.
      ck_ee = 1'b0; sr = 1'b1;
      step();
      check_eq("sr_video", video, 60);
      check_eq("sr_flags", {req, act, burst, phase}, 0);
      sr = 1'b0;

      // One-in-four enable: same timing in enabled cycles, holds in between.
      cnt = 0; req_rise = -1; act_rise = -1; en_idx = 0;
      for (int i = 0; i < 4 * H_TOTAL; i++) begin
         ck_ee = (i % 4 == 0);
         rand_yuv();
         step();
         if (ck_ee) begin
            if (act) cnt++;
            if (req && req_rise < 0) req_rise = en_idx;
            if (act && act_rise < 0) act_rise = en_idx;
            en_idx++;
         end
      end
      check_eq("ee_act_count", cnt, 768);
      check_eq("ee_req_lead", act_rise - req_rise, 2);

      // Random enable, restarts and flags.
      for (int i = 0; i < 1500; i++) begin
         ck_ee  = ($urandom_range(1) == 1);
         hstart = ($urandom_range(199) == 0);
         vsync  = ($urandom_range(3) == 0);
         vblank = ($urandom_range(2) == 0);
         rand_yuv();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
